alarm_controller: RTL and testbench

Downstream consumer of the digital clock's hours/minutes/seconds counters, clocked on the same clk_1hz tick. Holds a programmable alarm time, compares it against the running time once per second, and drives a ringing output with bounded duration, snooze with a retry limit, and stop/disarm controls. Its outputs feed the buzzer driver and display-status logic.

---
 rtl/alarm_controller.sv | 163 ++++++++++++++++
 tb/tb_alarm_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm controller fed by the clk_1hz time-of-day counters: stores an alarm time,
// rings on match, supports bounded ringing, limited snoozes, stop and disarm.
module alarm_controller #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       set_alarm,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       arm,
  input  logic       disarm,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       armed,
  output logic       ringing,
  output logic       snooze_active,
  output logic [1:0] snooze_count,
  output logic       set_err,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_RINGING = 2'd2;
  localparam logic [1:0] S_SNOOZE  = 2'd3;

  localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
  localparam logic [1:0] MAX_CNT     = 2'(MAX_SNOOZE);

  logic [1:0] r_state;
  logic [8:0] r_timer;
  logic [1:0] r_snooze_count;
  logic [4:0] r_alarm_hours;
  logic [5:0] r_alarm_minutes;
  logic       r_armed;
  logic       r_ringing;
  logic       r_snooze_active;
  logic       r_set_err;
  logic       r_snooze_d;
  logic       r_stop_d;

  logic [1:0] w_next_state;
  logic [8:0] w_next_timer;
  logic [1:0] w_next_count;
  logic       w_snooze_edge;
  logic       w_stop_edge;
  logic       w_match;
  logic       w_set_bad;

  assign w_snooze_edge = snooze & ~r_snooze_d;
  assign w_stop_edge   = stop & ~r_stop_d;
  // Compares against the alarm value held before any set_alarm on this tick.
  assign w_match   = (hours == r_alarm_hours) && (minutes == r_alarm_minutes) &&
                     (seconds == 6'd0);
  assign w_set_bad = (set_hours > 5'd23) || (set_minutes > 6'd59);

  always_comb begin
    w_next_state = r_state;
    w_next_timer = r_timer;
    w_next_count = r_snooze_count;
    if (disarm) begin
      w_next_state = S_IDLE;
      w_next_timer = 9'd0;
      w_next_count = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) w_next_state = S_ARMED;
        end
        S_ARMED: begin
          if (w_match) begin
            w_next_state = S_RINGING;
            w_next_timer = 9'd0;
            w_next_count = 2'd0;
          end
        end
        S_RINGING: begin
          if (w_stop_edge) begin
            w_next_state = S_ARMED;
            w_next_timer = 9'd0;
            w_next_count = 2'd0;
          end else if (w_snooze_edge && (r_snooze_count < MAX_CNT)) begin
            w_next_state = S_SNOOZE;
            w_next_timer = 9'd0;
            w_next_count = r_snooze_count + 2'd1;
          end else if (r_timer == RING_LAST) begin
            w_next_state = S_ARMED;
            w_next_timer = 9'd0;
            w_next_count = 2'd0;
          end else begin
            w_next_timer = r_timer + 9'd1;
          end
        end
        S_SNOOZE: begin
          if (w_stop_edge) begin
            w_next_state = S_ARMED;
            w_next_timer = 9'd0;
            w_next_count = 2'd0;
          end else if (r_timer == SNOOZE_LAST) begin
            w_next_state = S_RINGING;
            w_next_timer = 9'd0;
          end else begin
            w_next_timer = r_timer + 9'd1;
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_timer = 9'd0;
          w_next_count = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_timer         <= 9'd0;
      r_snooze_count  <= 2'd0;
      r_alarm_hours   <= 5'd0;
      r_alarm_minutes <= 6'd0;
      r_armed         <= 1'b0;
      r_ringing       <= 1'b0;
      r_snooze_active <= 1'b0;
      r_set_err       <= 1'b0;
      r_snooze_d      <= 1'b0;
      r_stop_d        <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_timer         <= w_next_timer;
      r_snooze_count  <= w_next_count;
      r_armed         <= (w_next_state != S_IDLE);
      r_ringing       <= (w_next_state == S_RINGING);
      r_snooze_active <= (w_next_state == S_SNOOZE);
      r_snooze_d      <= snooze;
      r_stop_d        <= stop;
      r_set_err       <= set_alarm & w_set_bad;
      if (set_alarm && !w_set_bad) begin
        r_alarm_hours   <= set_hours;
        r_alarm_minutes <= set_minutes;
      end
    end
  end

  assign alarm_hours   = r_alarm_hours;
  assign alarm_minutes = r_alarm_minutes;
  assign armed         = r_armed;
  assign ringing       = r_ringing;
  assign snooze_active = r_snooze_active;
  assign snooze_count  = r_snooze_count;
  assign set_err       = r_set_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus random stimulus, checked
// each tick against a countdown-based reference model through an expected queue.
module tb_alarm_controller;
  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;
  localparam int W    = 17;

  logic       clk_1hz = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] seconds = '0;
  logic [5:0] minutes = '0;
  logic [4:0] hours = '0;
  logic       set_alarm = 1'b0;
  logic [4:0] set_hours = '0;
  logic [5:0] set_minutes = '0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       armed;
  logic       ringing;
  logic       snooze_active;
  logic [1:0] snooze_count;
  logic       set_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  alarm_controller #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
    .clk_1hz(clk_1hz), .rst(rst), .seconds(seconds), .minutes(minutes), .hours(hours),
    .set_alarm(set_alarm), .set_hours(set_hours), .set_minutes(set_minutes),
    .arm(arm), .disarm(disarm), .snooze(snooze), .stop(stop),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .armed(armed),
    .ringing(ringing), .snooze_active(snooze_active), .snooze_count(snooze_count),
    .set_err(set_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_1hz = ~clk_1hz;

  // reference model: alarm described as enabled/ringing/snoozing flags with
  // countdowns of remaining ring and snooze ticks
  int m_ah, m_am, m_cnt, ring_left, snz_left;
  bit m_en, m_ring, m_snz, m_err, p_snooze, p_stop;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] model_vec();
    return {5'(m_ah), 6'(m_am), m_en, m_ring, m_snz, 2'(m_cnt), m_err};
  endfunction

  always @(posedge clk_1hz) begin
    bit snz_ev, stop_ev, hit;
    if (rst) begin
      m_ah = 0; m_am = 0; m_cnt = 0; ring_left = 0; snz_left = 0;
      m_en = 0; m_ring = 0; m_snz = 0; m_err = 0; p_snooze = 0; p_stop = 0;
    end else begin
      snz_ev  = snooze && !p_snooze;
      stop_ev = stop && !p_stop;
      p_snooze = snooze;
      p_stop   = stop;
      hit = (int'(hours) == m_ah) && (int'(minutes) == m_am) && (seconds == 0);
      m_err = 0;
      if (set_alarm) begin
        if (int'(set_hours) > 23 || int'(set_minutes) > 59) m_err = 1;
        else begin m_ah = int'(set_hours); m_am = int'(set_minutes); end
      end
      if (disarm) begin
        m_en = 0; m_ring = 0; m_snz = 0; m_cnt = 0;
      end else if (!m_en) begin
        if (arm) m_en = 1;
      end else if (m_ring) begin
        if (stop_ev) begin
          m_ring = 0; m_cnt = 0;
        end else if (snz_ev && m_cnt < MAXS) begin
          m_ring = 0; m_snz = 1; snz_left = SNZ; m_cnt++;
        end else begin
          ring_left--;
          if (ring_left == 0) begin m_ring = 0; m_cnt = 0; end
        end
      end else if (m_snz) begin
        if (stop_ev) begin
          m_snz = 0; m_cnt = 0;
        end else begin
          snz_left--;
          if (snz_left == 0) begin m_snz = 0; m_ring = 1; ring_left = RING; end
        end
      end else if (hit) begin
        m_ring = 1; ring_left = RING; m_cnt = 0;
      end
    end
    exp_q.push_back(model_vec());
  end

  // scoreboard monitor
  always @(negedge clk_1hz) begin
    logic [W-1:0] exp_v, got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {alarm_hours, alarm_minutes, armed, ringing, snooze_active, snooze_count, set_err};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL tick_outputs t=%0t got h=%0d m=%0d arm=%0b ring=%0b snz=%0b cnt=%0d err=%0b required h=%0d m=%0d arm=%0b ring=%0b snz=%0b cnt=%0d err=%0b",
                 $time, got_v[16:12], got_v[11:6], got_v[5], got_v[4], got_v[3], got_v[2:1], got_v[0],
                 exp_v[16:12], exp_v[11:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2:1], exp_v[0]);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_1hz);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
  endtask

  task automatic program_alarm(input int h, input int m);
    set_alarm = 1'b1; set_hours = 5'(h); set_minutes = 6'(m);
    tick(1);
    set_alarm = 1'b0;
  endtask

  task automatic fire_alarm();
    set_time(7, 30, 0);
    tick(1);
    set_time(12, 0, 5);
  endtask

  task automatic press_snooze();
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
  endtask

  task automatic async_reset_check();
    @(negedge clk_1hz);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({alarm_hours, alarm_minutes, armed, ringing, snooze_active, snooze_count, set_err, dbg_state} !== '0) begin
      n_errors++;
      $display("FAIL async_reset got h=%0d m=%0d arm=%0b ring=%0b snz=%0b cnt=%0d err=%0b st=%0d required all zero",
               alarm_hours, alarm_minutes, armed, ringing, snooze_active, snooze_count, set_err, dbg_state);
    end
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    set_time(12, 0, 5);
    tick(1);

    // program 07:30, arm, fire and let it time out
    program_alarm(7, 30);
    arm = 1'b1; tick(1); arm = 1'b0;
    set_time(7, 29, 59); tick(1);
    fire_alarm();
    tick(RING + 5);

    // snooze three times, fourth snooze ignored
    fire_alarm();
    tick(3);
    for (int i = 0; i < 4; i++) begin
      press_snooze();
      tick(SNZ + 4);
    end
    tick(RING);

    // simultaneous stop and snooze, stop held for five ticks
    fire_alarm();
    tick(3);
    stop = 1'b1; snooze = 1'b1;
    tick(5);
    stop = 1'b0; snooze = 1'b0;
    tick(3);

    // out-of-range and boundary alarm values
    program_alarm(24, 10);
    tick(2);
    program_alarm(23, 59);
    tick(2);
    program_alarm(7, 30);

    // disarm with arm while snoozing, then a match that must not ring
    fire_alarm();
    tick(2);
    press_snooze();
    tick(5);
    disarm = 1'b1; arm = 1'b1;
    tick(1);
    disarm = 1'b0; arm = 1'b0;
    tick(2);
    fire_alarm();
    tick(5);

    // asynchronous reset mid-ring
    arm = 1'b1; tick(1); arm = 1'b0;
    fire_alarm();
    tick(4);
    async_reset_check();
    tick(2);

    // randomized phase
    program_alarm(6, 15);
    for (int i = 0; i < 4000; i++) begin
      disarm    = ($urandom_range(0, 99) < 2);
      arm       = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 6) snooze = ~snooze;
      if ($urandom_range(0, 99) < 2) stop = ~stop;
      set_alarm = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 1) == 1) begin
        set_hours = 5'($urandom_range(0, 31)); set_minutes = 6'($urandom_range(0, 63));
      end else begin
        set_hours = 5'($urandom_range(0, 23)); set_minutes = 6'($urandom_range(0, 59));
      end
      if ($urandom_range(0, 5) == 0) set_time(m_ah, m_am, 0);
      else if ($urandom_range(0, 5) == 0) set_time(m_ah, m_am, $urandom_range(1, 59));
      else set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      tick(1);
    end
    disarm = 1'b0; arm = 1'b0; set_alarm = 1'b0; snooze = 1'b0; stop = 1'b0;
    tick(3);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
